ins_fetch_unit: RTL and testbench

- Instruction-fetch front end of the MIPS core. Owns the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Presents one instruction at a time to the decoder with a valid/ready handshake.
- Computes the next PC from the decoder's branch/jump controls (npc_sel, isJump, imm16, imm26) and the ALU zero flag when the decoder consumes the instruction.
- At most one memory request is outstanding at any time.

---
 rtl/mips_defs.sv | 23 ++
 rtl/npc_calc.sv | 40 ++++
 rtl/ins_fetch_unit.sv | 117 +++++++++++
 tb/tb_ins_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// mips_defs
// Shared definitions for the MIPS core slice: default reset PC, the fetch
// FSM state encoding, the opcode constants used by the decoder, and a
// helper that turns a 16-bit branch immediate into a byte offset.
package mips_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetchState_t;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  // Sign-extend the branch immediate and scale words to bytes.
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// npc_calc
// Purely combinational next-PC selection for the fetch unit.
// Ports:
//   pc      in  32  PC of the instruction being consumed
//   npcSel  in  1   beq decoded
//   isJump  in  1   j decoded (wins over npcSel)
//   aluZero in  1   beq compare result
//   imm16   in  16  branch offset in words
//   imm26   in  26  jump index in words
//   npc     out 32  selected next PC
module npc_calc
  import mips_defs::*;
(
  input  logic [31:0] pc,
  input  logic        npcSel,
  input  logic        isJump,
  input  logic        aluZero,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  output logic [31:0] npc
);

  logic [31:0] p4;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;

  // All adds wrap at 2^32; the jump keeps the top nibble of pc+4.
  always_comb begin
    p4           = pc + 32'd4;
    branchTarget = p4 + branchOffset(imm16);
    jumpTarget   = {p4[31:28], imm26, 2'b00};
    npc          = p4;
    if (isJump) begin
      npc = jumpTarget;
    end else if (npcSel && aluZero) begin
      npc = branchTarget;
    end
  end

endmodule

// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit
// Instruction-fetch front end: owns the PC, issues one word read at a time
// to instruction memory (req/gnt then rvalid), holds the returned word for
// the decoder (valid/ready) and advances the PC when it is consumed.
// Ports:
//   clk, rst_regFile                  clock, async active-high reset
//   imem_req/imem_addr                read request and word address
//   imem_gnt/imem_rvalid/imem_rdata   memory accept, data valid, data
//   instruction/pc_out/ins_valid      held word, its PC, valid flag
//   ins_ready                         decoder consumes this cycle
//   npc_sel/isJump/alu_zero/imm16/imm26  branch/jump controls
//   ins_count                         number of instructions consumed
module ins_fetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_regFile,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instruction,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [31:0]      pc_out,
  input  logic             npc_sel,
  input  logic             isJump,
  input  logic             alu_zero,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  output logic [CNT_W-1:0] ins_count
);

  fetchState_t state;
  fetchState_t nextState;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        consume;
  logic        latchData;

  npc_calc uNpcCalc (
    .pc      (pc),
    .npcSel  (npc_sel),
    .isJump  (isJump),
    .aluZero (alu_zero),
    .imm16   (imm16),
    .imm26   (imm26),
    .npc     (npc)
  );

  // Next-state and handshake outputs. The request is masked by reset so the
  // memory sees no request while the core is held in reset.
  always_comb begin
    nextState = state;
    imem_req  = 1'b0;
    imem_addr = pc;
    consume   = 1'b0;
    latchData = 1'b0;
    case (state)
      S_REQ: begin
        imem_req = ~rst_regFile;
        if (imem_gnt) begin
          nextState = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          latchData = 1'b1;
          nextState = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ins_ready) begin
          consume   = 1'b1;
          nextState = S_REQ;
        end
      end
      default: nextState = S_REQ;
    endcase
  end

  // State register; ins_valid is registered so it is high exactly in S_HOLD.
  always_ff @(posedge clk or posedge rst_regFile) begin
    if (rst_regFile) begin
      state     <= S_REQ;
      ins_valid <= 1'b0;
    end else begin
      state     <= nextState;
      ins_valid <= (nextState == S_HOLD);
    end
  end

  // Datapath: capture the returned word with its PC, and only advance the PC
  // and counter in the cycle the decoder takes the instruction.
  always_ff @(posedge clk or posedge rst_regFile) begin
    if (rst_regFile) begin
      pc          <= RESET_PC;
      pc_out      <= RESET_PC;
      instruction <= 32'h0;
      ins_count   <= '0;
    end else begin
      if (latchData) begin
        instruction <= imem_rdata;
        pc_out      <= pc;
      end
      if (consume) begin
        pc        <= npc;
        ins_count <= ins_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ins_fetch_unit.sv
// tb_ins_fetch_unit
// Directed bench for the fetch unit. dut runs from the default reset PC;
// dutWrap starts at the top of the address space with a 4-bit counter to
// exercise PC and counter wrap-around.
module tb_ins_fetch_unit;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        rst_regFile = 1'b1;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt = 1'b0;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = 32'h0;
  logic [31:0] instr;
  logic        insValid;
  logic        insReady = 1'b0;
  logic [31:0] pcOut;
  logic [31:0] insCount;

  logic        npcSel = 1'b0;
  logic        isJump = 1'b0;
  logic        aluZero = 1'b0;
  logic [15:0] imm16 = 16'h0;
  logic [25:0] imm26 = 26'h0;

  logic        req2;
  logic [31:0] addr2;
  logic        gnt2 = 1'b0;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = 32'h0;
  logic [31:0] instr2;
  logic        valid2;
  logic        ready2 = 1'b0;
  logic [31:0] pcOut2;
  logic [3:0]  count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ins_fetch_unit dut (
    .clk(clk), .rst_regFile(rst_regFile),
    .imem_req(imemReq), .imem_addr(imemAddr), .imem_gnt(imemGnt),
    .imem_rvalid(imemRvalid), .imem_rdata(imemRdata),
    .instruction(instr), .ins_valid(insValid), .ins_ready(insReady),
    .pc_out(pcOut), .npc_sel(npcSel), .isJump(isJump), .alu_zero(aluZero),
    .imm16(imm16), .imm26(imm26), .ins_count(insCount)
  );

  ins_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dutWrap (
    .clk(clk), .rst_regFile(rst_regFile),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .instruction(instr2), .ins_valid(valid2), .ins_ready(ready2),
    .pc_out(pcOut2), .npc_sel(npcSel), .isJump(isJump), .alu_zero(aluZero),
    .imm16(imm16), .imm26(imm26), .ins_count(count2)
  );

  // Stimulus helpers: each one drives for one cycle and returns just after
  // the following falling edge.
  task automatic grantReq();
    imemGnt = 1'b1;
    @(negedge clk);
    imemGnt = 1'b0;
  endtask

  task automatic returnData(input logic [31:0] data);
    imemRvalid = 1'b1;
    imemRdata  = data;
    @(negedge clk);
    imemRvalid = 1'b0;
  endtask

  task automatic consume(input logic sel, input logic jmp, input logic zero,
                         input logic [15:0] i16, input logic [25:0] i26);
    npcSel   = sel;
    isJump   = jmp;
    aluZero  = zero;
    imm16    = i16;
    imm26    = i26;
    insReady = 1'b1;
    @(negedge clk);
    insReady = 1'b0;
    npcSel   = 1'b0;
    isJump   = 1'b0;
    aluZero  = 1'b0;
    imm16    = 16'h0;
    imm26    = 26'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imemReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", imemReq); end
    checks++;
    if (insValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", insValid); end
    checks++;
    if (instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h want 0", instr); end
    checks++;
    if (insCount !== 32'h0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", insCount); end
    rst_regFile = 1'b0;
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h3000) begin
      errors++; $display("[TB] FAIL release_req got %b/%h want 1/00003000", imemReq, imemAddr);
    end
  endtask

  task automatic test_straight();
    grantReq();
    checks++;
    if (imemReq !== 1'b0) begin errors++; $display("[TB] FAIL wait_req got %b want 0", imemReq); end
    returnData(32'h0000_0020);
    checks++;
    if (insValid !== 1'b1 || instr !== 32'h0000_0020 || pcOut !== 32'h3000) begin
      errors++; $display("[TB] FAIL straight_hold got v=%b i=%h pc=%h want 1/00000020/00003000", insValid, instr, pcOut);
    end
    consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h3004 || insCount !== 32'd1 || insValid !== 1'b0) begin
      errors++; $display("[TB] FAIL straight_next got r=%b a=%h c=%0d v=%b want 1/00003004/1/0", imemReq, imemAddr, insCount, insValid);
    end
    grantReq(); returnData(32'h1111_1111); consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    checks++;
    if (imemAddr !== 32'h3008) begin errors++; $display("[TB] FAIL straight_3008 got %h want 00003008", imemAddr); end
  endtask

  task automatic test_branch();
    grantReq(); returnData(32'h1000_FFFE);
    consume(1'b1, 1'b0, 1'b1, 16'hFFFE, 26'h0);
    checks++;
    if (imemAddr !== 32'h3004) begin errors++; $display("[TB] FAIL branch_taken got %h want 00003004", imemAddr); end
    grantReq(); returnData(32'h2222_2222); consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    grantReq(); returnData(32'h1000_FFFE);
    consume(1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0);
    checks++;
    if (imemAddr !== 32'h300C) begin errors++; $display("[TB] FAIL branch_not_taken got %h want 0000300c", imemAddr); end
    grantReq(); returnData(32'h3333_3333); consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
  endtask

  task automatic test_jump();
    grantReq(); returnData(32'h0800_0C10);
    checks++;
    if (pcOut !== 32'h3010) begin errors++; $display("[TB] FAIL jump_pc got %h want 00003010", pcOut); end
    consume(1'b1, 1'b1, 1'b1, 16'hFFFE, 26'h000_0C10);
    checks++;
    if (imemAddr !== 32'h3040 || insCount !== 32'd7) begin
      errors++; $display("[TB] FAIL jump_target got %h c=%0d want 00003040 c=7", imemAddr, insCount);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (imemReq !== 1'b1 || imemAddr !== 32'h3040) begin
        errors++; $display("[TB] FAIL gnt_stall%0d got %b/%h want 1/00003040", i, imemReq, imemAddr);
      end
    end
    grantReq();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (insValid !== 1'b0 || imemReq !== 1'b0) begin
        errors++; $display("[TB] FAIL rvalid_stall%0d got v=%b r=%b want 0/0", i, insValid, imemReq);
      end
    end
    returnData(32'hDEAD_BEEF);
    checks++;
    if (insValid !== 1'b1 || instr !== 32'hDEAD_BEEF || pcOut !== 32'h3040) begin
      errors++; $display("[TB] FAIL late_latch got v=%b i=%h pc=%h want 1/deadbeef/00003040", insValid, instr, pcOut);
    end
    for (int i = 0; i < 4; i++) begin
      isJump = 1'b1;
      imm26  = 26'h3FF_FFFF;
      if (i == 1) begin
        imemRvalid = 1'b1;
        imemRdata  = 32'h1234_5678;
      end
      @(negedge clk);
      imemRvalid = 1'b0;
      checks++;
      if (insValid !== 1'b1 || instr !== 32'hDEAD_BEEF || pcOut !== 32'h3040 || imemReq !== 1'b0) begin
        errors++; $display("[TB] FAIL hold%0d got v=%b i=%h pc=%h r=%b want 1/deadbeef/00003040/0", i, insValid, instr, pcOut, imemReq);
      end
    end
    consume(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    checks++;
    if (imemAddr !== 32'h3044 || insCount !== 32'd8) begin
      errors++; $display("[TB] FAIL after_hold got %h c=%0d want 00003044 c=8", imemAddr, insCount);
    end
  endtask

  task automatic test_reset_mid();
    grantReq();
    rst_regFile = 1'b1;
    #1;
    checks++;
    if (insValid !== 1'b0 || imemReq !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_wait got v=%b r=%b want 0/0", insValid, imemReq);
    end
    @(negedge clk);
    rst_regFile = 1'b0;
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h3000 || insCount !== 32'd0) begin
      errors++; $display("[TB] FAIL rst_wait_release got r=%b a=%h c=%0d want 1/00003000/0", imemReq, imemAddr, insCount);
    end
    grantReq(); returnData(32'hAAAA_5555);
    checks++;
    if (insValid !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_hold got %b want 1", insValid); end
    rst_regFile = 1'b1;
    #1;
    checks++;
    if (insValid !== 1'b0 || imemReq !== 1'b0 || instr !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_hold got v=%b r=%b i=%h want 0/0/0", insValid, imemReq, instr);
    end
    @(negedge clk);
    rst_regFile = 1'b0;
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h3000 || insCount !== 32'd0) begin
      errors++; $display("[TB] FAIL rst_hold_release got r=%b a=%h c=%0d want 1/00003000/0", imemReq, imemAddr, insCount);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] expAddr;
    expAddr = 32'hFFFF_FFFC;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (addr2 !== expAddr || req2 !== 1'b1) begin
        errors++; $display("[TB] FAIL wrap_addr%0d got %b/%h want 1/%h", i, req2, addr2, expAddr);
      end
      gnt2 = 1'b1;
      @(negedge clk);
      gnt2    = 1'b0;
      rvalid2 = 1'b1;
      rdata2  = 32'(i);
      @(negedge clk);
      rvalid2 = 1'b0;
      if (i == 15) begin
        checks++;
        if (count2 !== 4'hF || valid2 !== 1'b1) begin
          errors++; $display("[TB] FAIL wrap_count_full got %h v=%b want f/1", count2, valid2);
        end
      end
      ready2 = 1'b1;
      @(negedge clk);
      ready2  = 1'b0;
      expAddr = expAddr + 32'd4;
    end
    checks++;
    if (count2 !== 4'h0 || addr2 !== 32'h0000_003C) begin
      errors++; $display("[TB] FAIL wrap_count got %h a=%h want 0/0000003c", count2, addr2);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_branch();
    test_jump();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
